// File: rtl/id_hazard_controller.sv
// Decode-stage hazard controller: load-use and branch-operand stall detection,
// pipeline enables/flush, immediate-extension select, post-reset hold and stall statistics.
//
// Ports:
//   Clk, Reset (async, active-low)
//   IFID_Instr      instruction in ID
//   IDEX_MemRead, IDEX_RegWrite, IDEX_WriteReg   EX-stage producer info
//   EXMEM_MemRead, EXMEM_WriteReg                MEM-stage producer info
//   BranchTaken, Jump                            ID redirect requests
//   PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush  pipeline control
//   ExtMode         00 sign, 01 zero, 10 imm<<16
//   StallCount      saturating stall-cycle total
//   HazardErr       sticky too-many-consecutive-stalls flag
module id_hazard_controller #(
    parameter int RESET_HOLD = 4,
    parameter int MAX_STALL  = 3
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] IFID_Instr,
    input  logic        IDEX_MemRead,
    input  logic        IDEX_RegWrite,
    input  logic [4:0]  IDEX_WriteReg,
    input  logic        EXMEM_MemRead,
    input  logic [4:0]  EXMEM_WriteReg,
    input  logic        BranchTaken,
    input  logic        Jump,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IDEX_Bubble,
    output logic        IFID_Flush,
    output logic [1:0]  ExtMode,
    output logic [15:0] StallCount,
    output logic        HazardErr
);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam logic [15:0] ERR_AT = 16'(MAX_STALL + 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_hold;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_consec;
    logic        r_err;

    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic        w_uses_rs;
    logic        w_uses_rt;
    logic        w_is_branch;
    logic        w_match_ex;
    logic        w_match_mem;
    logic        w_load_use;
    logic        w_br_haz;
    logic        w_stall;
    logic        w_active;
    logic        w_unused;

    assign w_op = IFID_Instr[31:26];
    assign w_rs = IFID_Instr[25:21];
    assign w_rt = IFID_Instr[20:16];

    // Immediate and funct fields are consumed elsewhere in ID.
    assign w_unused = ^IFID_Instr[15:0];

    assign w_uses_rs = !(w_op inside {6'h02, 6'h03, 6'h0F});
    assign w_uses_rt = (w_op inside {6'h00, 6'h04, 6'h05,
                                     6'h28, 6'h29, 6'h2B});
    assign w_is_branch = (w_op inside {6'h01, 6'h04, 6'h05,
                                       6'h06, 6'h07});

    // $0 is hardwired, so a write to it can never create a dependency.
    assign w_match_ex = (IDEX_WriteReg != 5'd0) &&
                        ((w_uses_rs && IDEX_WriteReg == w_rs) ||
                         (w_uses_rt && IDEX_WriteReg == w_rt));
    assign w_match_mem = (EXMEM_WriteReg != 5'd0) &&
                         ((w_uses_rs && EXMEM_WriteReg == w_rs) ||
                          (w_uses_rt && EXMEM_WriteReg == w_rt));

    assign w_load_use = IDEX_MemRead && w_match_ex;

    // Branches compare in ID, so any in-flight producer not yet
    // forwardable to ID (ALU op in EX, load in MEM) must be waited out.
    assign w_br_haz = w_is_branch &&
                      ((IDEX_RegWrite && w_match_ex) ||
                       (EXMEM_MemRead && w_match_mem));

    assign w_stall  = w_load_use || w_br_haz;
    assign w_active = (r_state != INIT);

    always_comb begin
        w_next      = r_state;
        PCWrite     = 1'b0;
        IFIDWrite   = 1'b0;
        IDEX_Bubble = 1'b1;
        IFID_Flush  = 1'b1;
        ExtMode     = 2'b00;
        unique case (r_state)
            INIT: begin
                if (r_hold == 4'd1) begin
                    w_next = RUN;
                end
            end
            RUN, STALL: begin
                unique case (1'b1)
                    (w_op inside {6'h0C, 6'h0D, 6'h0E}): ExtMode = 2'b01;
                    (w_op == 6'h0F):                      ExtMode = 2'b10;
                    default:                              ExtMode = 2'b00;
                endcase
                // A stall overrides redirects: the branch operands are stale.
                if (w_stall) begin
                    IFID_Flush = 1'b0;
                    w_next     = STALL;
                end else begin
                    PCWrite     = 1'b1;
                    IFIDWrite   = 1'b1;
                    IDEX_Bubble = 1'b0;
                    IFID_Flush  = BranchTaken || Jump;
                    w_next      = RUN;
                end
            end
            default: begin
                w_next = INIT;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state     <= INIT;
            r_hold      <= 4'(RESET_HOLD);
            r_stall_cnt <= 16'd0;
            r_consec    <= 16'd0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (!w_active) begin
                r_hold <= r_hold - 4'd1;
            end else if (w_stall) begin
                if (r_stall_cnt != 16'hFFFF) begin
                    r_stall_cnt <= r_stall_cnt + 16'd1;
                end
                // Saturate once the error threshold is reached.
                if (r_consec < ERR_AT) begin
                    r_consec <= r_consec + 16'd1;
                end
                if (r_consec + 16'd1 >= ERR_AT) begin
                    r_err <= 1'b1;
                end
            end else begin
                r_consec <= 16'd0;
            end
        end
    end

    assign StallCount = r_stall_cnt;
    assign HazardErr  = r_err;

endmodule

// File: tb/tb_id_hazard_controller.sv
// Testbench for id_hazard_controller: directed scenarios plus randomized
// traffic against a behavioural reference model.
module tb_id_hazard_controller;

    localparam int HOLD = 4;
    localparam int MAXS = 3;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] IFID_Instr;
    logic        IDEX_MemRead;
    logic        IDEX_RegWrite;
    logic [4:0]  IDEX_WriteReg;
    logic        EXMEM_MemRead;
    logic [4:0]  EXMEM_WriteReg;
    logic        BranchTaken;
    logic        Jump;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        IDEX_Bubble;
    logic        IFID_Flush;
    logic [1:0]  ExtMode;
    logic [15:0] StallCount;
    logic        HazardErr;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit m_init;
    int m_hold;
    int m_cnt;
    int m_consec;
    bit m_err;

    id_hazard_controller #(.RESET_HOLD(HOLD), .MAX_STALL(MAXS)) dut (
        .Clk(Clk), .Reset(Reset), .IFID_Instr(IFID_Instr),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrite(IDEX_RegWrite),
        .IDEX_WriteReg(IDEX_WriteReg), .EXMEM_MemRead(EXMEM_MemRead),
        .EXMEM_WriteReg(EXMEM_WriteReg), .BranchTaken(BranchTaken),
        .Jump(Jump), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .IDEX_Bubble(IDEX_Bubble), .IFID_Flush(IFID_Flush),
        .ExtMode(ExtMode), .StallCount(StallCount), .HazardErr(HazardErr)
    );

    always #5 Clk = ~Clk;

    function automatic bit reads_reg(input logic [31:0] ins, input logic [4:0] x);
        int op;
        bit urs, urt;
        op  = int'(ins[31:26]);
        urs = !(op == 2 || op == 3 || op == 15);
        urt = (op == 0 || op == 4 || op == 5 || op == 40 || op == 41 || op == 43);
        return (x != 0) && ((urs && x == ins[25:21]) || (urt && x == ins[20:16]));
    endfunction

    function automatic bit m_stall();
        int op;
        bit br;
        op = int'(IFID_Instr[31:26]);
        br = (op == 1) || (op >= 4 && op <= 7);
        return (IDEX_MemRead && reads_reg(IFID_Instr, IDEX_WriteReg)) ||
               (br && ((IDEX_RegWrite && reads_reg(IFID_Instr, IDEX_WriteReg)) ||
                       (EXMEM_MemRead && reads_reg(IFID_Instr, EXMEM_WriteReg))));
    endfunction

    // {PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, ExtMode}
    function automatic logic [5:0] m_ctl();
        int op;
        bit s;
        logic [1:0] e;
        if (m_init) return 6'b001100;
        op = int'(IFID_Instr[31:26]);
        s  = m_stall();
        e  = (op >= 12 && op <= 14) ? 2'b01 : (op == 15) ? 2'b10 : 2'b00;
        return {!s, !s, s, !s && (BranchTaken || Jump), e};
    endfunction

    function automatic logic [5:0] dut_ctl();
        return {PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, ExtMode};
    endfunction

    task automatic m_reset();
        m_init = 1; m_hold = HOLD; m_cnt = 0; m_consec = 0; m_err = 0;
    endtask

    // Advance one rising edge, updating the model with the inputs seen there.
    task automatic tick();
        bit s;
        @(posedge Clk);
        if (!Reset) begin
            m_reset();
        end else if (m_init) begin
            if (m_hold == 1) m_init = 0;
            else m_hold--;
        end else begin
            s = m_stall();
            if (s) begin
                if (m_cnt < 65535) m_cnt++;
                m_consec++;
                if (m_consec > MAXS) m_err = 1;
            end else begin
                m_consec = 0;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        IFID_Instr = 32'h0; IDEX_MemRead = 0; IDEX_RegWrite = 0;
        IDEX_WriteReg = 0; EXMEM_MemRead = 0; EXMEM_WriteReg = 0;
        BranchTaken = 0; Jump = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        Reset = 0; m_reset();
        repeat (3) tick();
        Reset = 1;
        repeat (HOLD) tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        Reset = 0; m_reset();
        #1;
        checks++;
        if (dut_ctl() !== 6'b001100 || StallCount !== 16'd0 || HazardErr !== 1'b0) begin
            failures++;
            $display("FAIL reset_async got ctl=%b cnt=%0d err=%b need ctl=001100 cnt=0 err=0",
                     dut_ctl(), StallCount, HazardErr);
        end
        repeat (3) tick();
        Reset = 1;
        for (int k = 0; k < HOLD; k++) begin
            @(negedge Clk);
            checks++;
            if (PCWrite !== 1'b0 || IDEX_Bubble !== 1'b1 || IFID_Flush !== 1'b1) begin
                failures++;
                $display("FAIL reset_hold%0d got pc=%b bub=%b fl=%b need 0 1 1",
                         k, PCWrite, IDEX_Bubble, IFID_Flush);
            end
            tick();
        end
        @(negedge Clk);
        checks++;
        if (PCWrite !== 1'b1 || StallCount !== 16'd0) begin
            failures++;
            $display("FAIL reset_run got pc=%b cnt=%0d need pc=1 cnt=0", PCWrite, StallCount);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        IDEX_MemRead = 1; IDEX_RegWrite = 1; IDEX_WriteReg = 8;
        IFID_Instr = 32'h01095020;
        @(negedge Clk);
        checks++;
        if (PCWrite !== 1'b0 || IDEX_Bubble !== 1'b1) begin
            failures++;
            $display("FAIL load_use_stall got pc=%b bub=%b need 0 1", PCWrite, IDEX_Bubble);
        end
        tick();
        IDEX_MemRead = 0; IDEX_RegWrite = 0; IDEX_WriteReg = 0;
        @(negedge Clk);
        checks++;
        if (PCWrite !== 1'b1 || StallCount !== 16'd1) begin
            failures++;
            $display("FAIL load_use_release got pc=%b cnt=%0d need pc=1 cnt=1", PCWrite, StallCount);
        end
    endtask

    task automatic test_branch();
        do_reset();
        IFID_Instr = 32'h11000003; BranchTaken = 1;
        IDEX_MemRead = 1; IDEX_RegWrite = 1; IDEX_WriteReg = 8;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                IDEX_MemRead = 0; IDEX_RegWrite = 0; IDEX_WriteReg = 0;
                EXMEM_MemRead = 1; EXMEM_WriteReg = 8;
            end
            if (k == 2) begin
                EXMEM_MemRead = 0; EXMEM_WriteReg = 0;
            end
            @(negedge Clk);
            checks++;
            if (PCWrite !== (k == 2) || IFID_Flush !== (k == 2) || IDEX_Bubble !== (k != 2)) begin
                failures++;
                $display("FAIL branch_cyc%0d got pc=%b fl=%b bub=%b need pc=%b fl=%b bub=%b",
                         k, PCWrite, IFID_Flush, IDEX_Bubble, k == 2, k == 2, k != 2);
            end
            tick();
        end
        checks++;
        if (StallCount !== 16'd2) begin
            failures++;
            $display("FAIL branch_count got %0d need 2", StallCount);
        end
        BranchTaken = 0;
    endtask

    task automatic test_r0_ext();
        logic [31:0] ins [4];
        logic [1:0]  ext [4];
        ins[0] = 32'h01204820; ext[0] = 2'b00;
        ins[1] = 32'h3508FFFF; ext[1] = 2'b01;
        ins[2] = 32'h3C081234; ext[2] = 2'b10;
        ins[3] = 32'h2108FFFF; ext[3] = 2'b00;
        do_reset();
        IDEX_MemRead = 1; IDEX_RegWrite = 1; IDEX_WriteReg = 0;
        IFID_Instr = 32'h00004820;
        @(negedge Clk);
        checks++;
        if (PCWrite !== 1'b1 || IDEX_Bubble !== 1'b0) begin
            failures++;
            $display("FAIL r0_no_stall got pc=%b bub=%b need 1 0", PCWrite, IDEX_Bubble);
        end
        tick();
        idle_inputs();
        for (int k = 1; k < 4; k++) begin
            IFID_Instr = ins[k];
            @(negedge Clk);
            checks++;
            if (ExtMode !== ext[k]) begin
                failures++;
                $display("FAIL extmode_%08h got %b need %b", ins[k], ExtMode, ext[k]);
            end
            tick();
        end
    endtask

    task automatic test_hazard_err();
        do_reset();
        IDEX_MemRead = 1; IDEX_WriteReg = 8; IFID_Instr = 32'h01095020;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            checks++;
            if (HazardErr !== m_err || PCWrite !== 1'b0) begin
                failures++;
                $display("FAIL herr_cyc%0d got err=%b pc=%b need err=%b pc=0",
                         k, HazardErr, PCWrite, m_err);
            end
            tick();
        end
        idle_inputs();
        @(negedge Clk);
        checks++;
        if (HazardErr !== 1'b1 || StallCount !== 16'd5 || PCWrite !== 1'b1) begin
            failures++;
            $display("FAIL herr_sticky got err=%b cnt=%0d pc=%b need 1 5 1",
                     HazardErr, StallCount, PCWrite);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        do_reset();
        IDEX_MemRead = 1; IDEX_WriteReg = 8; IFID_Instr = 32'h01095020;
        repeat (5) tick();
        #2;
        Reset = 0; m_reset();
        #1;
        checks++;
        if (dut_ctl() !== 6'b001100 || StallCount !== 16'd0 || HazardErr !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got ctl=%b cnt=%0d err=%b need ctl=001100 cnt=0 err=0",
                     dut_ctl(), StallCount, HazardErr);
        end
        tick();
        Reset = 1;
    endtask

    task automatic test_random();
        logic [5:0] ops [15];
        logic [5:0] exp;
        ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h28, 6'h2B};
        do_reset();
        for (int k = 0; k < 400; k++) begin
            IFID_Instr = {ops[$urandom_range(14)], 5'($urandom_range(3)),
                          5'($urandom_range(3)), 16'($urandom)};
            IDEX_MemRead   = 1'($urandom_range(1));
            IDEX_RegWrite  = 1'($urandom_range(1));
            IDEX_WriteReg  = 5'($urandom_range(3));
            EXMEM_MemRead  = 1'($urandom_range(1));
            EXMEM_WriteReg = 5'($urandom_range(3));
            BranchTaken    = 1'($urandom_range(1));
            Jump           = ($urandom_range(7) == 0);
            if (k == 200) begin
                Reset = 0; m_reset();
            end
            if (k == 203) Reset = 1;
            @(negedge Clk);
            exp = m_ctl();
            checks++;
            if (dut_ctl() !== exp || StallCount !== 16'(m_cnt) || HazardErr !== m_err) begin
                failures++;
                $display("FAIL random%0d ins=%08h got ctl=%b cnt=%0d err=%b need ctl=%b cnt=%0d err=%b",
                         k, IFID_Instr, dut_ctl(), StallCount, HazardErr, exp, m_cnt, m_err);
            end
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        Reset = 0;
        m_reset();
        test_reset();
        test_load_use();
        test_branch();
        test_r0_ext();
        test_hazard_err();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
